// File: rtl/i2s_deserialize_if.sv
// Sample-side port of the I2S receiver: one captured word with its channel tag,
// a valid/ready handshake and two sticky error flags.
interface i2s_deserialize_if #(
    parameter int unsigned bit_depth = 18
);
    logic [bit_depth-1:0] sample_data;
    logic                 sample_channel;
    logic                 sample_valid;
    logic                 sample_ready;
    logic                 overrun;
    logic                 frame_err;

    modport master (
        output sample_data,
        output sample_channel,
        output sample_valid,
        output overrun,
        output frame_err,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_channel,
        input  sample_valid,
        input  overrun,
        input  frame_err,
        output sample_ready
    );
endinterface

// File: rtl/i2s_deserialize.sv
// I2S receiver on BCLK: aligns to LRCLK edges, shifts SD in MSB-first with the
// one-BCLK I2S delay and presents each word with its channel on a valid/ready port.
module i2s_deserialize #(
    parameter int unsigned bit_depth = 18
) (
    input  logic              BCLK,
    input  logic              RST,
    input  logic              LRCLK,
    input  logic              SD,
    i2s_deserialize_if.master bus
);
    localparam int unsigned CNT_W = $clog2(bit_depth);
    localparam int unsigned SH_W  = bit_depth - 1;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SH_W-1:0]      shift_q, shift_d;
    logic                 chan_q, chan_d;
    logic                 lr_d_q;
    logic [bit_depth-1:0] data_q, data_d;
    logic                 ochan_q, ochan_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 ferr_q, ferr_d;
    logic                 lr_edge_c;
    logic                 done_c;

    // Next-state and output-register logic; the LSB completes the word on the same edge it is sampled.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        chan_d    = chan_q;
        data_d    = data_q;
        ochan_d   = ochan_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        ferr_d    = ferr_q;
        lr_edge_c = (LRCLK != lr_d_q);
        done_c    = (state_q == SHIFT) && (cnt_q == CNT_W'(bit_depth - 1));

        case (state_q)
            SYNC: begin
                if (lr_edge_c) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    chan_d  = LRCLK;
                end
            end
            SHIFT: begin
                shift_d = SH_W'({shift_q, SD});
                if (lr_edge_c) begin
                    // A word cut short by a new slot is discarded and flagged.
                    state_d = SHIFT;
                    cnt_d   = '0;
                    chan_d  = LRCLK;
                    if (!done_c) begin
                        ferr_d = 1'b1;
                    end
                end else if (done_c) begin
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (lr_edge_c) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    chan_d  = LRCLK;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase

        if (valid_q && bus.sample_ready) begin
            valid_d = 1'b0;
        end
        if (done_c) begin
            if (!valid_q || bus.sample_ready) begin
                data_d  = {shift_q, SD};
                ochan_d = chan_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge BCLK) begin
        if (RST) begin
            state_q   <= SYNC;
            cnt_q     <= '0;
            shift_q   <= '0;
            chan_q    <= 1'b0;
            lr_d_q    <= LRCLK;
            data_q    <= '0;
            ochan_q   <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            chan_q    <= chan_d;
            lr_d_q    <= LRCLK;
            data_q    <= data_d;
            ochan_q   <= ochan_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.sample_data    = data_q;
    assign bus.sample_channel = ochan_q;
    assign bus.sample_valid   = valid_q;
    assign bus.overrun        = overrun_q;
    assign bus.frame_err      = ferr_q;
endmodule

// File: tb/tb_i2s_deserialize.sv
// Bench for i2s_deserialize: drives I2S slots like a transmitter and compares accepted
// words against a slot-level model (top bit_depth bits of each full slot after sync).
module tb_i2s_deserialize;
    localparam int unsigned BD = 18;

    logic BCLK = 1'b0;
    logic RST;
    logic LRCLK;
    logic SD;

    i2s_deserialize_if #(.bit_depth(BD)) bus ();

    i2s_deserialize #(.bit_depth(BD)) dut (
        .BCLK (BCLK),
        .RST  (RST),
        .LRCLK(LRCLK),
        .SD   (SD),
        .bus  (bus)
    );

    always #5 BCLK = ~BCLK;

    int          checks;
    int          errors;
    logic [BD:0] got[$];
    logic [BD:0] exp[$];
    bit          in_slot;
    int          prev_len;
    bit          model_ferr;
    logic        carry;
    logic        cur_lr;

    // Record every word that crosses the handshake (inputs are stable from negedge to posedge).
    always @(negedge BCLK) begin
        if (RST === 1'b0 && bus.sample_valid === 1'b1 && bus.sample_ready === 1'b1)
            got.push_back({bus.sample_channel, bus.sample_data});
    end

    task automatic idle(input int n);
        repeat (n) @(negedge BCLK);
    endtask

    task automatic set_ready(input logic v);
        @(posedge BCLK);
        #2;
        bus.sample_ready = v;
    endtask

    task automatic do_reset();
        @(posedge BCLK);
        #2;
        RST = 1'b1;
        @(posedge BCLK);
        #2;
        RST = 1'b0;
        got.delete();
        exp.delete();
        in_slot    = 1'b0;
        prev_len   = 0;
        model_ferr = 1'b0;
    endtask

    // One slot of nbits on channel lr; MSB goes out one BCLK after the LRCLK change.
    task automatic send_slot(input logic lr, input logic [31:0] bits, input int nbits,
                             input bit keep, input int ready_bit);
        bit edge_s;
        edge_s = (lr !== cur_lr);
        if (edge_s) begin
            if (in_slot && prev_len < int'(BD)) model_ferr = 1'b1;
            in_slot = 1'b1;
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge BCLK);
            LRCLK = lr;
            SD    = (i == 0) ? carry : bits[nbits - i];
            if (i == ready_bit) begin
                @(posedge BCLK);
                #2;
                bus.sample_ready = 1'b1;
            end
        end
        carry  = bits[0];
        cur_lr = lr;
        if (edge_s) prev_len = nbits;
        else prev_len += nbits;
        if (in_slot && edge_s && nbits > int'(BD) && keep)
            exp.push_back({lr, BD'(bits >> (nbits - int'(BD)))});
    endtask

    task automatic test_reset();
        repeat (2) @(posedge BCLK);
        @(negedge BCLK);
        checks++; if (bus.sample_data !== '0) begin errors++; $display("FAIL rst_data got %h want 0", bus.sample_data); end
        checks++; if (bus.sample_channel !== 1'b0) begin errors++; $display("FAIL rst_chan got %b want 0", bus.sample_channel); end
        checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.sample_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", bus.overrun); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr got %b want 0", bus.frame_err); end
        RST = 1'b0;
        got.delete();
        exp.delete();
    endtask

    task automatic test_loopback();
        logic [31:0] w;
        do_reset();
        send_slot(1'b0, {18'h2A5A5, 14'h0}, 32, 1'b1, -1);
        send_slot(1'b1, {18'h1C3C3, 14'h0}, 32, 1'b1, -1);
        send_slot(1'b0, {18'h2A5A5, 14'h0}, 32, 1'b1, -1);
        send_slot(1'b1, {18'h1C3C3, 14'h0}, 32, 1'b1, -1);
        for (int s = 0; s < 10; s++) begin
            w = $urandom;
            send_slot(~cur_lr, w, int'($urandom_range(32, 20)), 1'b1, -1);
        end
        idle(3);
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL loop_count got %0d want %0d", got.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL loop_word[%0d] got %h want %h", k, got[k], exp[k]); end
        end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL loop_ferr got %b want 0", bus.frame_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL loop_overrun got %b want 0", bus.overrun); end
    endtask

    task automatic test_mid_word_start();
        send_slot(~cur_lr, $urandom, 10, 1'b1, -1);
        do_reset();
        send_slot(cur_lr, $urandom, 22, 1'b1, -1);
        send_slot(~cur_lr, $urandom, 32, 1'b1, -1);
        send_slot(~cur_lr, $urandom, 28, 1'b1, -1);
        idle(3);
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL mid_count got %0d want %0d", got.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL mid_word[%0d] got %h want %h", k, got[k], exp[k]); end
        end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL mid_ferr got %b want 0", bus.frame_err); end
    endtask

    task automatic test_overrun();
        do_reset();
        set_ready(1'b0);
        send_slot(~cur_lr, $urandom, 32, 1'b1, -1);
        idle(2);
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", bus.overrun); end
        send_slot(~cur_lr, $urandom, 32, 1'b0, -1);
        idle(2);
        checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", bus.sample_valid); end
        checks++; if ({bus.sample_channel, bus.sample_data} !== exp[0]) begin errors++; $display("FAIL ovr_held got %h want %h", {bus.sample_channel, bus.sample_data}, exp[0]); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", bus.overrun); end
        send_slot(~cur_lr, $urandom, 30, 1'b1, 17);
        idle(3);
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL ovr_count got %0d want %0d", got.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL ovr_word[%0d] got %h want %h", k, got[k], exp[k]); end
        end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", bus.overrun); end
    endtask

    task automatic test_frame_err();
        do_reset();
        send_slot(~cur_lr, $urandom, 32, 1'b1, -1);
        idle(2);
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_early got %b want 0", bus.frame_err); end
        send_slot(~cur_lr, $urandom, 10, 1'b1, -1);
        send_slot(~cur_lr, $urandom, 32, 1'b1, -1);
        send_slot(~cur_lr, $urandom, 25, 1'b1, -1);
        idle(3);
        checks++; if (bus.frame_err !== model_ferr) begin errors++; $display("FAIL ferr_flag got %b want %b", bus.frame_err, model_ferr); end
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL ferr_count got %0d want %0d", got.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL ferr_word[%0d] got %h want %h", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_bit_positions();
        do_reset();
        send_slot(~cur_lr, 32'h8000_0000, 32, 1'b1, -1);
        send_slot(~cur_lr, 32'h0000_4000, 32, 1'b1, -1);
        send_slot(~cur_lr, 32'h0000_3FFF, 32, 1'b1, -1);
        send_slot(~cur_lr, 32'hFFFF_C000, 32, 1'b1, -1);
        idle(3);
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL bits_count got %0d want %0d", got.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL bits_word[%0d] got %h want %h", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_reset_mid_shift();
        do_reset();
        set_ready(1'b0);
        send_slot(~cur_lr, $urandom, 32, 1'b0, -1);
        send_slot(~cur_lr, $urandom, 32, 1'b0, -1);
        send_slot(~cur_lr, $urandom, 12, 1'b0, -1);
        checks++; if (bus.sample_valid !== 1'b1 || bus.overrun !== 1'b1) begin errors++; $display("FAIL rms_pre got v=%b o=%b want v=1 o=1", bus.sample_valid, bus.overrun); end
        do_reset();
        @(negedge BCLK);
        checks++; if (bus.sample_data !== '0 || bus.sample_channel !== 1'b0) begin errors++; $display("FAIL rms_data got %h/%b want 0/0", bus.sample_data, bus.sample_channel); end
        checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL rms_valid got %b want 0", bus.sample_valid); end
        checks++; if (bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin errors++; $display("FAIL rms_flags got o=%b f=%b want 0/0", bus.overrun, bus.frame_err); end
        set_ready(1'b1);
        send_slot(cur_lr, $urandom, 20, 1'b1, -1);
        send_slot(~cur_lr, $urandom, 32, 1'b1, -1);
        send_slot(~cur_lr, $urandom, 24, 1'b1, -1);
        idle(3);
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL rms_count got %0d want %0d", got.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL rms_word[%0d] got %h want %h", k, got[k], exp[k]); end
        end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rms_ferr got %b want 0", bus.frame_err); end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        RST              = 1'b1;
        LRCLK            = 1'b1;
        SD               = 1'b0;
        bus.sample_ready = 1'b1;
        cur_lr           = 1'b1;
        carry            = 1'b0;
        in_slot          = 1'b0;
        prev_len         = 0;
        model_ferr       = 1'b0;
        test_reset();
        test_loopback();
        test_mid_word_start();
        test_overrun();
        test_frame_err();
        test_bit_positions();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
